// File: rtl/uart_pkg.sv
// Shared UART package: default widths/depths, FIFO operation encoding and a
// constant clog2 helper used by the UART TX/RX blocks and the RX FIFO.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Operation applied to the FIFO on a clock edge: {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for uart_rx_fifo: one synchronous write port, one asynchronous
// read port, every entry cleared while rst is high.
module fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array is reset so a popped-empty FIFO reads back 0 after reset;
    // this costs a reset net per bit and forbids mapping to block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver. The sticky
// overflow flag is built only when UART_RX_FIFO_OVERFLOW_FLAG_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic                      i_wr_en,
    input  logic                      i_rd_en,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [clog2(DEPTH):0]     o_count,
    output logic                      o_overflow,
    input  logic                      i_ovf_clr
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_ovf_evt;
    fifo_op_t      w_op;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_COUNT);
    assign o_count = r_count;

    // When full, a write is only accepted if a pop frees the head slot on the same edge.
    assign w_rd_ok   = i_rd_en && !o_empty;
    assign w_wr_ok   = i_wr_en && (!o_full || w_rd_ok);
    assign w_ovf_evt = i_wr_en && o_full && !w_rd_ok;
    assign w_op      = fifo_op_t'({w_wr_ok, w_rd_ok});

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case (w_op)
                OP_WR:   r_count <= r_count + CW'(1);
                OP_RD:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    // A fresh drop wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_overflow = r_overflow;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = &{1'b0, i_ovf_clr, w_ovf_evt};
    assign o_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, a per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
`ifdef UART_RX_FIFO_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              rd_en;
    logic              ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [3:0]        count;
    logic              overflow;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model_q [$];
    bit                model_ovf;
    bit                cmp_en;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr_data  (wr_data),
        .i_wr_en    (wr_en),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_empty    (empty),
        .o_full     (full),
        .o_count    (count),
        .o_overflow (overflow),
        .i_ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle and advance the model by the FIFO rules at the same edge.
    task automatic step(input bit wr, input logic [7:0] data, input bit rd, input bit clr);
        bit m_full, m_empty, rd_ok, wr_ok, evt;
        wr_en   = wr;
        wr_data = data;
        rd_en   = rd;
        ovf_clr = clr;
        @(posedge clk);
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        rd_ok   = rd && !m_empty;
        wr_ok   = wr && (!m_full || rd_ok);
        evt     = wr && m_full && !rd_ok;
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(data);
        if (OVF_EN) begin
            if (evt) model_ovf = 1'b1;
            else if (clr) model_ovf = 1'b0;
        end
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cyc_count", count, model_q.size());
            check("cyc_empty", empty, model_q.size() == 0);
            check("cyc_full", full, model_q.size() == DEPTH);
            check("cyc_ovf", overflow, model_ovf);
            if (model_q.size() != 0) check("cyc_head", rd_data, model_q[0]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmp_en  = 1'b0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        wr_data = '0;
        model_ovf = 1'b0;
        #3;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_data", rd_data, 0);
        check("rst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        // Single byte, one-cycle fall-through, then pop.
        step(1, 8'h41, 0, 0);
        check("wr41_count", count, 1);
        check("wr41_empty", empty, 0);
        check("wr41_data", rd_data, 8'h41);
        step(0, 0, 1, 0);
        check("pop41_empty", empty, 1);
        check("pop41_count", count, 0);

        // Fill, drop, drain in order.
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        step(1, 8'h09, 0, 0);
        check("drop_count", count, 8);
        check("drop_ovf", overflow, OVF_EN ? 1 : 0);
        // Drop coinciding with clear keeps the flag set.
        step(1, 8'h0A, 0, 1);
        check("drop_clr_ovf", overflow, OVF_EN ? 1 : 0);
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", rd_data, i);
            step(0, 0, 1, 0);
        end
        check("drain_empty", empty, 1);
        step(0, 0, 0, 1);
        check("clr_ovf", overflow, 0);

        // Full FIFO, simultaneous write and pop.
        for (int i = 1; i <= 8; i++) step(1, 8'(8'h60 + i), 0, 0);
        step(1, 8'hAA, 1, 0);
        check("fullrw_count", count, 8);
        check("fullrw_ovf", overflow, 0);
        check("fullrw_head", rd_data, 8'h62);
        repeat (7) step(0, 0, 1, 0);
        check("fullrw_tail", rd_data, 8'hAA);
        step(0, 0, 1, 0);

        // Empty FIFO, simultaneous write and pop: pop ignored.
        step(1, 8'h55, 1, 0);
        check("emptyrw_count", count, 1);
        check("emptyrw_data", rd_data, 8'h55);
        step(0, 0, 1, 0);

        // Pointer wrap-around.
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h10 + i), 0, 0);
            check("wrap_data", rd_data, 8'h10 + i);
            check("wrap_le8", count <= 4'd8, 1);
            step(0, 0, 1, 0);
        end

        // Asynchronous reset with 5 stored entries.
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
        if (OVF_EN) begin
            for (int i = 0; i < 4; i++) step(1, 8'hE0, 0, 0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_data", rd_data, 0);
        check("arst_ovf", overflow, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            int wp;
            wp = (n < 400) ? 70 : 35;
            step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < 50,
                 $urandom_range(99) < 10);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
